// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode power-up sequencer and single-command issuer over a byte-wide SPI engine.
// Optional macro SD_CRC7_EN: compute a real CRC7 for every command instead of the fixed CRC table.
module sd_init_sequencer #(
    parameter int unsigned INIT_BYTES   = 10,
    parameter int unsigned R1_POLL      = 8,
    parameter int unsigned ACMD41_TRIES = 1000
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    output logic        TX_STB,
    output logic [7:0]  TX_DATA,
    input  logic        TX_ACK,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DATA,
    output logic        RX_ACK,
    output logic        CS,
    input  logic        CMD_STB,
    input  logic [5:0]  CMD_IDX,
    input  logic [31:0] CMD_ARG,
    output logic        CMD_ACK,
    output logic        RESP_STB,
    output logic [7:0]  RESP_DATA,
    output logic        READY,
    output logic        ERROR,
    output logic [1:0]  ERR_CODE,
    output logic        SDHC
);

    localparam int unsigned CNT_MAX = (INIT_BYTES > R1_POLL) ? INIT_BYTES : R1_POLL;
    localparam int unsigned CW      = $clog2(CNT_MAX + 8);
    localparam int unsigned TW      = $clog2(ACMD41_TRIES + 1);

    localparam logic [2:0] S_DUMMY  = 3'd0;
    localparam logic [2:0] S_CMD0   = 3'd1;
    localparam logic [2:0] S_CMD8   = 3'd2;
    localparam logic [2:0] S_CMD55  = 3'd3;
    localparam logic [2:0] S_ACMD41 = 3'd4;
    localparam logic [2:0] S_READY  = 3'd5;
    localparam logic [2:0] S_USER   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_LAUNCH = 2'd1;
    localparam logic [1:0] PH_XFER   = 2'd2;
    localparam logic [1:0] PH_EVAL   = 2'd3;

    localparam logic [1:0] SEG_CMD   = 2'd0;
    localparam logic [1:0] SEG_POLL  = 2'd1;
    localparam logic [1:0] SEG_EXTRA = 2'd2;
    localparam logic [1:0] SEG_TRAIL = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [1:0]    seg_q, seg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [7:0]    r1_q, r1_d;
    logic [15:0]   ext_q, ext_d;
    logic [7:0]    rx_q, rx_d;
    logic          tx_done_q, tx_done_d;
    logic          rx_done_q, rx_done_d;
    logic [5:0]    uidx_q, uidx_d;
    logic [31:0]   uarg_q, uarg_d;

    logic          tx_stb_d, rx_ack_d, cs_d, cmd_ack_d, resp_stb_d;
    logic [7:0]    tx_data_d, resp_data_d;
    logic          ready_d, error_d, sdhc_d;
    logic [1:0]    err_code_d;

    logic [5:0]    cur_idx;
    logic [31:0]   cur_arg;
    logic [7:0]    crc_byte;
    logic [7:0]    frame_byte;

`ifdef SD_CRC7_EN
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
`endif

    // Command index/argument for the frame currently being sent
    always_comb begin
        cur_idx = uidx_q;
        cur_arg = uarg_q;
        case (state_q)
            S_CMD0:   begin cur_idx = 6'd0;  cur_arg = 32'h0000_0000; end
            S_CMD8:   begin cur_idx = 6'd8;  cur_arg = 32'h0000_01AA; end
            S_CMD55:  begin cur_idx = 6'd55; cur_arg = 32'h0000_0000; end
            S_ACMD41: begin cur_idx = 6'd41; cur_arg = SDHC ? 32'h4000_0000 : 32'h0000_0000; end
            default:  ;
        endcase
    end

    always_comb begin
`ifdef SD_CRC7_EN
        crc_byte = {crc7({2'b01, cur_idx, cur_arg}), 1'b1};
`else
        if (cur_idx == 6'd0)      crc_byte = 8'h95;
        else if (cur_idx == 6'd8) crc_byte = 8'h87;
        else                      crc_byte = 8'h01;
`endif
    end

    always_comb begin
        case (cnt_q)
            CW'(0):  frame_byte = {2'b01, cur_idx};
            CW'(1):  frame_byte = cur_arg[31:24];
            CW'(2):  frame_byte = cur_arg[23:16];
            CW'(3):  frame_byte = cur_arg[15:8];
            CW'(4):  frame_byte = cur_arg[7:0];
            default: frame_byte = crc_byte;
        endcase
    end

    // Next-state: byte-exchange handshake, frame segmentation and init decisions
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        seg_d       = seg_q;
        cnt_d       = cnt_q;
        tries_d     = tries_q;
        r1_d        = r1_q;
        ext_d       = ext_q;
        rx_d        = rx_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        uidx_d      = uidx_q;
        uarg_d      = uarg_q;
        tx_stb_d    = TX_STB;
        tx_data_d   = TX_DATA;
        cs_d        = CS;
        rx_ack_d    = 1'b0;
        cmd_ack_d   = 1'b0;
        resp_stb_d  = 1'b0;
        resp_data_d = RESP_DATA;
        ready_d     = READY;
        error_d     = ERROR;
        err_code_d  = ERR_CODE;
        sdhc_d      = SDHC;

        case (phase_q)
            PH_LAUNCH: begin
                tx_stb_d  = 1'b1;
                tx_done_d = 1'b0;
                rx_done_d = 1'b0;
                phase_d   = PH_XFER;
                if (state_q == S_DUMMY || seg_q == SEG_TRAIL) begin
                    cs_d      = 1'b1;
                    tx_data_d = 8'hFF;
                end else if (seg_q == SEG_CMD) begin
                    cs_d      = 1'b0;
                    tx_data_d = frame_byte;
                end else begin
                    cs_d      = 1'b0;
                    tx_data_d = 8'hFF;
                end
            end
            PH_XFER: begin
                if (TX_STB && TX_ACK) begin
                    tx_stb_d  = 1'b0;
                    tx_done_d = 1'b1;
                end
                if (RX_STB && !rx_done_q) begin
                    rx_d      = RX_DATA;
                    rx_done_d = 1'b1;
                    rx_ack_d  = 1'b1;
                end
                if (tx_done_q && rx_done_q) phase_d = PH_EVAL;
            end
            PH_EVAL: begin
                phase_d = PH_LAUNCH;
                if (state_q == S_DUMMY) begin
                    if (cnt_q >= CW'(INIT_BYTES - 1)) begin
                        state_d = S_CMD0;
                        seg_d   = SEG_CMD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    case (seg_q)
                        SEG_CMD: begin
                            if (cnt_q >= CW'(5)) begin
                                seg_d = SEG_POLL;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        SEG_POLL: begin
                            if (!rx_q[7]) begin
                                r1_d  = rx_q;
                                cnt_d = '0;
                                seg_d = (state_q == S_CMD8 && rx_q == 8'h01) ? SEG_EXTRA : SEG_TRAIL;
                            end else if (cnt_q >= CW'(R1_POLL - 1)) begin
                                r1_d  = 8'hFF;
                                cnt_d = '0;
                                seg_d = SEG_TRAIL;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        SEG_EXTRA: begin
                            ext_d = {ext_q[7:0], rx_q};
                            if (cnt_q >= CW'(3)) begin
                                seg_d = SEG_TRAIL;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            // Trailing byte done: the command is complete, decide where to go
                            seg_d = SEG_CMD;
                            cnt_d = '0;
                            case (state_q)
                                S_CMD0: begin
                                    if (r1_q == 8'h01) begin
                                        state_d = S_CMD8;
                                    end else begin
                                        state_d = S_ERROR;  err_code_d = 2'd1;
                                    end
                                end
                                S_CMD8: begin
                                    if (r1_q == 8'h01 && ext_q == 16'h01AA) begin
                                        sdhc_d  = 1'b1;
                                        state_d = S_CMD55;
                                    end else if (!r1_q[7] && r1_q[2]) begin
                                        sdhc_d  = 1'b0;
                                        state_d = S_CMD55;
                                    end else begin
                                        state_d = S_ERROR;  err_code_d = 2'd2;
                                    end
                                end
                                S_CMD55: state_d = S_ACMD41;
                                S_ACMD41: begin
                                    if (r1_q == 8'h00) begin
                                        state_d = S_READY;
                                    end else if (32'(tries_q) + 32'd1 >= ACMD41_TRIES) begin
                                        state_d = S_ERROR;  err_code_d = 2'd3;
                                    end else begin
                                        tries_d = tries_q + TW'(1);
                                        state_d = S_CMD55;
                                    end
                                end
                                S_USER: begin
                                    resp_stb_d  = 1'b1;
                                    resp_data_d = r1_q;
                                    state_d     = S_READY;
                                end
                                default: ;
                            endcase
                            if (state_d == S_READY) begin
                                ready_d = 1'b1;
                                phase_d = PH_IDLE;
                            end else if (state_d == S_ERROR) begin
                                error_d = 1'b1;
                                cs_d    = 1'b1;
                                phase_d = PH_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (state_q == S_READY && CMD_STB) begin
                    cmd_ack_d = 1'b1;
                    uidx_d    = CMD_IDX;
                    uarg_d    = CMD_ARG;
                    ready_d   = 1'b0;
                    state_d   = S_USER;
                    seg_d     = SEG_CMD;
                    cnt_d     = '0;
                    phase_d   = PH_LAUNCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_DUMMY;
            phase_q   <= PH_LAUNCH;
            seg_q     <= SEG_CMD;
            cnt_q     <= '0;
            tries_q   <= '0;
            r1_q      <= 8'hFF;
            ext_q     <= '0;
            rx_q      <= 8'hFF;
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            uidx_q    <= '0;
            uarg_q    <= '0;
            TX_STB    <= 1'b0;
            TX_DATA   <= 8'hFF;
            RX_ACK    <= 1'b0;
            CS        <= 1'b1;
            CMD_ACK   <= 1'b0;
            RESP_STB  <= 1'b0;
            RESP_DATA <= 8'hFF;
            READY     <= 1'b0;
            ERROR     <= 1'b0;
            ERR_CODE  <= 2'd0;
            SDHC      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            tries_q   <= tries_d;
            r1_q      <= r1_d;
            ext_q     <= ext_d;
            rx_q      <= rx_d;
            tx_done_q <= tx_done_d;
            rx_done_q <= rx_done_d;
            uidx_q    <= uidx_d;
            uarg_q    <= uarg_d;
            TX_STB    <= tx_stb_d;
            TX_DATA   <= tx_data_d;
            RX_ACK    <= rx_ack_d;
            CS        <= cs_d;
            CMD_ACK   <= cmd_ack_d;
            RESP_STB  <= resp_stb_d;
            RESP_DATA <= resp_data_d;
            READY     <= ready_d;
            ERROR     <= error_d;
            ERR_CODE  <= err_code_d;
            SDHC      <= sdhc_d;
        end
    end

endmodule
